// File: rtl/alu_accumulator_pkg.sv
// Shared opcode map, ALU class/op sub-codes and flag bit positions for the
// accumulator execution stage.
package alu_accumulator_pkg;

  localparam logic [7:0] OpNop    = 8'h00;
  localparam logic [7:0] OpLoadX  = 8'h10;
  localparam logic [7:0] OpLoadI  = 8'h14;
  localparam logic [7:0] OpStoreX = 8'h20;
  localparam logic [7:0] OpStoreI = 8'h24;
  localparam logic [7:0] OpJmp    = 8'hC0;
  localparam logic [7:0] OpJz     = 8'hC1;
  localparam logic [7:0] OpJc     = 8'hC2;
  localparam logic [7:0] OpJn     = 8'hC3;
  localparam logic [7:0] OpJv     = 8'hC4;

  // Upper five IR bits select the class; IR[2] picks the operand, IR[1:0] the op.
  localparam logic [4:0] ClsArithPfx = 5'b01000;
  localparam logic [4:0] ClsLogicPfx = 5'b10000;

  localparam logic [1:0] OpAdd  = 2'd0;
  localparam logic [1:0] OpSub  = 2'd1;
  localparam logic [1:0] OpAddc = 2'd2;
  localparam logic [1:0] OpSubc = 2'd3;

  localparam logic [1:0] OpNor  = 2'd0;
  localparam logic [1:0] OpNand = 2'd1;
  localparam logic [1:0] OpXor  = 2'd2;
  localparam logic [1:0] OpXnor = 2'd3;

  localparam int unsigned FlagZero  = 0;
  localparam int unsigned FlagCarry = 1;
  localparam int unsigned FlagNeg   = 2;
  localparam int unsigned FlagOv    = 3;

  typedef enum logic {
    AluArith,
    AluLogic
  } alu_class_e;

endpackage

// File: rtl/alu_accumulator_alu_core.sv
// Combinational ALU: add/subtract with carry-in and signed overflow, or a
// bitwise NOR/NAND/XOR/XNOR.
module alu_core
  import alu_accumulator_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  input  alu_class_e       alu_class_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] result_o,
  output logic             cout_o,
  output logic             ov_o
);

  logic [Width-1:0] b_eff;
  logic             carry_in;
  logic [Width:0]   sum;

  always_comb begin
    b_eff = op_i[0] ? ~b_i : b_i;
    case (op_i)
      OpAdd:   carry_in = 1'b0;
      OpSub:   carry_in = 1'b1;
      default: carry_in = cin_i;
    endcase
    sum = {1'b0, a_i} + {1'b0, b_eff} + {{Width{1'b0}}, carry_in};

    result_o = sum[Width-1:0];
    cout_o   = sum[Width];
    ov_o     = (a_i[Width-1] == b_eff[Width-1]) && (sum[Width-1] != a_i[Width-1]);

    if (alu_class_i == AluLogic) begin
      cout_o = 1'b0;
      ov_o   = 1'b0;
      case (op_i)
        OpNor:   result_o = ~(a_i | b_i);
        OpNand:  result_o = ~(a_i & b_i);
        OpXor:   result_o = a_i ^ b_i;
        default: result_o = ~(a_i ^ b_i);
      endcase
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// Execution stage: decodes IR on the Exec pulse, updates AR and Flags one
// cycle later and strobes done / illegal_op.
module alu_accumulator
  import alu_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned INST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  Exec,
  input  logic [INST_WIDTH-1:0] IR,
  input  logic [DATA_WIDTH-1:0] IBR,
  input  logic [DATA_WIDTH-1:0] MBR,
  output logic [DATA_WIDTH-1:0] AR,
  output logic [3:0]            Flags,
  output logic                  done,
  output logic                  illegal_op
);

  logic [DATA_WIDTH-1:0] ar_d, ar_q;
  logic [3:0]            flags_d, flags_q;
  logic                  done_d, done_q;
  logic                  illegal_d, illegal_q;

  logic [7:0]            opc;
  logic                  is_arith, is_logic, is_load, is_hold;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_cout, alu_ov;

  assign opc      = IR[7:0];
  assign is_arith = (opc[7:3] == ClsArithPfx);
  assign is_logic = (opc[7:3] == ClsLogicPfx);
  assign is_load  = (opc == OpLoadX) || (opc == OpLoadI);
  assign is_hold  = (opc == OpStoreX) || (opc == OpStoreI) || (opc == OpNop) ||
                    (opc == OpJmp) || (opc == OpJz) || (opc == OpJc) ||
                    (opc == OpJn) || (opc == OpJv);
  assign operand  = opc[2] ? IBR : MBR;

  alu_core #(
    .Width (DATA_WIDTH)
  ) u_alu_core (
    .a_i         (ar_q),
    .b_i         (operand),
    .cin_i       (flags_q[FlagCarry]),
    .alu_class_i (is_logic ? AluLogic : AluArith),
    .op_i        (opc[1:0]),
    .result_o    (alu_result),
    .cout_o      (alu_cout),
    .ov_o        (alu_ov)
  );

  always_comb begin
    ar_d      = ar_q;
    flags_d   = flags_q;
    done_d    = Exec;
    illegal_d = 1'b0;
    if (Exec) begin
      if (is_arith || is_logic) begin
        ar_d               = alu_result;
        flags_d[FlagZero]  = ~|alu_result;
        flags_d[FlagNeg]   = alu_result[DATA_WIDTH-1];
        flags_d[FlagCarry] = alu_cout;
        flags_d[FlagOv]    = alu_ov;
      end else if (is_load) begin
        // Loads leave CARRY/OV alone so a following ADDC/SUBC still chains.
        ar_d              = operand;
        flags_d[FlagZero] = ~|operand;
        flags_d[FlagNeg]  = operand[DATA_WIDTH-1];
      end else if (!is_hold) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ar_q      <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ar_q      <= ar_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign AR         = ar_q;
  assign Flags      = flags_q;
  assign done       = done_q;
  assign illegal_op = illegal_q;

endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Execution stage directly downstream of the instruction-cycle FSM.
- Consumes its Exec pulse, IR, IBR (immediate operand) and MBR (memory operand). Owns the accumulator AR and the ALU flag register.
- Feeds AR and Flags back to the FSM, which uses them for STORE_X/STORE_I and conditional jumps.
- AR and Flags are registered: they change only on a clock edge where Exec=1.

Parameters:
- DATA_WIDTH, 8, width of AR, IBR, MBR and the datapath.
- INST_WIDTH, 8, width of IR.

Ports:
- clk  input  1  system clock, rising edge
- arst_n  input  1  asynchronous active-low reset
- Exec  input  1  execute strobe from the FSM; 1-cycle pulse, back-to-back legal
- IR  input  INST_WIDTH  opcode of the current instruction
- IBR  input  DATA_WIDTH  immediate operand
- MBR  input  DATA_WIDTH  memory operand, valid in the same cycle as Exec
- AR  output  DATA_WIDTH  accumulator (registered)
- Flags  output  4  {OV, NEG, CARRY, ZERO} at bit positions 3, 2, 1, 0 (registered)
- done  output  1  1-cycle pulse, the cycle after any Exec
- illegal_op  output  1  1-cycle pulse, the cycle after Exec with an undecodable IR

Behaviour:
- Reset (arst_n=0, any time, including mid-instruction): AR=0, Flags=0, done=0, illegal_op=0 immediately.
  - First Exec acted on is the first rising edge with arst_n=1 and Exec=1.
- Operands are sampled on the rising edge where Exec=1. Results are visible one cycle later (latency 1), together with done=1.
- Exec=0: AR and Flags hold regardless of IR, IBR or MBR.
- Operand select: IR[2]=0 uses MBR (memory form); IR[2]=1 uses IBR (immediate form).
- Arithmetic class, IR=0100_0s_op:
  - op 00 ADD: AR+B
  - op 01 SUB: AR+~B+1
  - op 10 ADDC: AR+B+C
  - op 11 SUBC: AR+~B+C
  - Computed at DATA_WIDTH+1 bits; CARRY = bit DATA_WIDTH. For subtraction CARRY=1 means no borrow.
  - OV = signed overflow: operand MSBs equal (after inversion for subtraction) and result MSB differs.
  - ZERO = (result==0); NEG = result MSB.
- Logic class, IR=1000_0s_op:
  - op 00 NOR, 01 NAND, 10 XOR, 11 XNOR of AR and B.
  - ZERO and NEG updated; CARRY and OV cleared.
- LOAD_X uses MBR; LOAD_I uses IBR.
  - AR <= operand; ZERO and NEG updated; CARRY and OV unchanged.
- STORE_X, STORE_I, NOP, JMP, JZ, JC, JN, JV: AR and Flags unchanged; done still pulses.
  - Flags must not change in this cycle, because the FSM evaluates jumps against them.
- Any other IR with Exec=1: AR and Flags unchanged; done=1 and illegal_op=1 for one cycle.
- Back-to-back Exec: the second operation uses the AR produced by the first (registered feedback, no bypass hazard).
- Wrap-around: all results are truncated to DATA_WIDTH; carry is captured only in CARRY.
- No internal state beyond AR, Flags, done and illegal_op. Control is fully decoded from IR in the Exec cycle.

Decomposition:
- Shared defines file holds:
  - opcode constants (LOAD_I, LOAD_X, STORE_X, STORE_I, NOP, JMP, JZ, JC, JN, JV)
  - class prefixes ARITH=6'b0100_0x and LOGIC=6'b1000_0x, plus op sub-codes
  - flag indices ZERO=0, CARRY=1, NEG=2, OV=3
- One combinational sub-module, alu_core: takes (a, b, cin, class, op) and returns result, cout and ov.
- alu_accumulator keeps decode, operand select, registers and the done/illegal_op strobes.

Test Plan:
- Reset mid-operation: LOAD_I IBR=0x55 with Exec, then pull arst_n low before the next edge -> AR=0x00, Flags=4'b0000, done=0 asynchronously; no update after release until the next Exec.
- LOAD_I 0x7F, then ADD_I 0x01 back-to-back -> AR=0x80; Flags: OV=1, NEG=1, CARRY=0, ZERO=0; done high one cycle after each Exec.
- LOAD_I 0xFF, ADD_I 0x01 -> AR=0x00, ZERO=1, CARRY=1, OV=0. Then ADDC_I 0x00 -> AR=0x01, CARRY=0, ZERO=0.
- LOAD_I 0x03, SUB_X with MBR=0x05 -> AR=0xFE, CARRY=0 (borrow), NEG=1. Then SUBC_X with MBR=0x00 -> AR=0xFD, CARRY=1.
- Logic and no-op handling:
  - AR=0xF0 with CARRY=1 set, then XNOR_I 0x0F -> AR=0x00, ZERO=1, CARRY=0, OV=0.
  - Then STORE_X and JZ with Exec -> AR and Flags unchanged, done=1 each time.
- Decode guards:
  - Exec=1 with IR=0xFF -> illegal_op=1 for one cycle; AR and Flags unchanged.
  - IR=ADD_I with IBR=0x10 and Exec=0 for 5 cycles -> AR unchanged, done=0.
